// File: rtl/checksum_sched_pkg.sv
// Shared types and default widths for the checksum job scheduler.
// Widths match the checksum_top datapath the scheduler feeds.
package checksum_sched_pkg;

   localparam int DEF_IN_DATA_WIDTH = 17;
   localparam int DEF_POLY_WIDTH    = 17;
   localparam int DEF_SUM_WIDTH     = 34;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } sched_state_t;

endpackage

// File: rtl/checksum_job_sched_rr_arbiter.sv
// Combinational round-robin select: first requester at or after rr_ptr, wrapping.
module sched_rr_arbiter
   import checksum_sched_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]  req,
   input  logic [ID_WIDTH-1:0] rr_ptr,
   output logic [NUM_REQ-1:0]  gnt_onehot,
   output logic [ID_WIDTH-1:0] gnt_id
);

   localparam int IW = ID_WIDTH + 1;

   logic [IW-1:0] idx;
   logic          found;

   always_comb begin
      gnt_onehot = '0;
      gnt_id     = '0;
      found      = 1'b0;
      idx        = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = IW'(rr_ptr) + IW'(i);
         if (idx >= IW'(NUM_REQ))
            idx = idx - IW'(NUM_REQ);
         if (!found && req[idx[ID_WIDTH-1:0]]) begin
            found                          = 1'b1;
            gnt_id                         = idx[ID_WIDTH-1:0];
            gnt_onehot[idx[ID_WIDTH-1:0]] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/checksum_job_sched.sv
// Round-robin job scheduler in front of one shared checksum_top datapath.
// Streams the granted burst, holds the polynomial for the whole job, returns a tagged result.
module checksum_job_sched
   import checksum_sched_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int ID_WIDTH       = 2,
   parameter int IN_DATA_WIDTH  = DEF_IN_DATA_WIDTH,
   parameter int POLY_WIDTH     = DEF_POLY_WIDTH,
   parameter int SUM_WIDTH      = DEF_SUM_WIDTH,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_REQ-1:0]                req_vld,
   input  logic [NUM_REQ-1:0]                req_last,
   input  logic [NUM_REQ*IN_DATA_WIDTH-1:0]  req_data,
   input  logic [NUM_REQ*POLY_WIDTH-1:0]     req_poly,
   output logic [NUM_REQ-1:0]                req_rdy,
   output logic                              dp_in_vld,
   output logic [IN_DATA_WIDTH-1:0]          dp_in_data,
   output logic [POLY_WIDTH-1:0]             dp_poly,
   input  logic [SUM_WIDTH-1:0]              dp_out_data,
   input  logic                              dp_out_vld,
   output logic                              rsp_vld,
   input  logic                              rsp_rdy,
   output logic [SUM_WIDTH-1:0]              rsp_data,
   output logic [ID_WIDTH-1:0]               rsp_id,
   output logic                              rsp_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   sched_state_t              state;
   logic [ID_WIDTH-1:0]       gnt_id;
   logic [ID_WIDTH-1:0]       rr_ptr;
   logic [ID_WIDTH-1:0]       arb_id;
   logic [NUM_REQ-1:0]        arb_onehot;
   logic [CNT_W-1:0]          tmo_cnt;
   logic [POLY_WIDTH-1:0]     sel_poly;
   logic [IN_DATA_WIDTH-1:0]  gnt_word;
   logic                      accept;

   sched_rr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_arb (
      .req        (req_vld),
      .rr_ptr     (rr_ptr),
      .gnt_onehot (arb_onehot),
      .gnt_id     (arb_id)
   );

   always_comb begin
      sel_poly = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++)
         if (arb_onehot[i])
            sel_poly = req_poly[i*POLY_WIDTH +: POLY_WIDTH];
   end

   always_comb begin
      req_rdy = '0;
      if (state == STREAM)
         req_rdy[gnt_id] = 1'b1;
   end

   assign gnt_word = req_data[gnt_id*IN_DATA_WIDTH +: IN_DATA_WIDTH];
   assign accept   = (state == STREAM) && req_vld[gnt_id];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         gnt_id      <= '0;
         rr_ptr      <= '0;
         tmo_cnt     <= '0;
         dp_in_vld   <= 1'b0;
         dp_in_data  <= '0;
         dp_poly     <= '0;
         rsp_vld     <= 1'b0;
         rsp_data    <= '0;
         rsp_id      <= '0;
         rsp_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               dp_in_vld <= 1'b0;
               if (|arb_onehot) begin
                  gnt_id  <= arb_id;
                  dp_poly <= sel_poly;
                  state   <= STREAM;
               end
            end
            STREAM: begin
               dp_in_vld <= accept;
               if (accept) begin
                  dp_in_data <= gnt_word;
                  if (req_last[gnt_id]) begin
                     tmo_cnt <= '0;
                     state   <= WAIT;
                  end
               end
            end
            WAIT: begin
               dp_in_vld <= 1'b0;
               // A result arriving on the timeout cycle still takes priority.
               if (dp_out_vld) begin
                  rsp_data    <= dp_out_data;
                  rsp_timeout <= 1'b0;
                  rsp_id      <= gnt_id;
                  rsp_vld     <= 1'b1;
                  state       <= RESP;
               end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  rsp_data    <= '0;
                  rsp_timeout <= 1'b1;
                  rsp_id      <= gnt_id;
                  rsp_vld     <= 1'b1;
                  state       <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            RESP: begin
               if (rsp_rdy) begin
                  rsp_vld <= 1'b0;
                  rr_ptr  <= (gnt_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/checksum_job_sched.md
Name: checksum_job_sched

Overview:
- Schedules jobs from NUM_REQ requesters onto one shared checksum_top datapath instance.
- Grants requesters round-robin and streams the granted requester's burst into the datapath.
- Holds the polynomial stable until the result is returned. checksum_top's output sign-correction reads the polynomial MSB combinationally, so the polynomial must not change mid-job.
- Captures the datapath result, or flags a timeout, and returns it tagged with the requester id.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, requester id width; must equal clog2(NUM_REQ).
- IN_DATA_WIDTH, 17, data word width.
- POLY_WIDTH, 17, polynomial width; bit 16 is the sign.
- SUM_WIDTH, 34, result width.
- TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT for dp_out_vld.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_vld  in  NUM_REQ  per-requester word valid.
- req_last  in  NUM_REQ  per-requester last word of burst.
- req_data  in  NUM_REQ*IN_DATA_WIDTH  packed words; requester i occupies slice i.
- req_poly  in  NUM_REQ*POLY_WIDTH  packed polynomials.
- req_rdy  out  NUM_REQ  per-requester word accept.
- dp_in_vld  out  1  to checksum_top in_data_vld.
- dp_in_data  out  IN_DATA_WIDTH  to checksum_top in_data.
- dp_poly  out  POLY_WIDTH  to checksum_top polynomial.
- dp_out_data  in  SUM_WIDTH  from checksum_top out_data.
- dp_out_vld  in  1  from checksum_top out_data_vld.
- rsp_vld  out  1  result valid.
- rsp_rdy  in  1  result accept.
- rsp_data  out  SUM_WIDTH  checksum result; 0 on timeout.
- rsp_id  out  ID_WIDTH  requester id of the result.
- rsp_timeout  out  1  result produced by timeout.

Behaviour:
- Reset (any time, including mid-job):
  - state IDLE, rr_ptr 0, grant id 0, timeout count 0.
  - All outputs 0; req_rdy all 0.
  - Any in-flight job is discarded.
- FSM states: IDLE, STREAM, WAIT, RESP.
- IDLE:
  - Any req_vld high → select the first requester with req_vld, searching rr_ptr, rr_ptr+1, … (mod NUM_REQ).
  - Register gnt_id and dp_poly <= req_poly[gnt], then go to STREAM.
  - No word is accepted in the grant cycle.
- STREAM:
  - req_rdy[gnt_id] = 1, combinational on state; all other req_rdy bits are 0.
  - On req_vld & req_rdy: next cycle dp_in_vld = 1 and dp_in_data = the word (registered, 1-cycle latency).
  - dp_in_vld = 0 on cycles with no accepted word; gaps are allowed.
  - Accepted word has req_last = 1 → go to WAIT.
  - Single-word bursts are legal.
  - req_poly changes after grant are ignored.
- WAIT:
  - Timeout counter increments every cycle; it is cleared on entry to WAIT.
  - dp_out_vld is sampled only in WAIT; any dp_out_vld during IDLE or STREAM is ignored.
  - dp_out_vld = 1 → rsp_data <= dp_out_data, rsp_timeout <= 0, go to RESP.
  - Counter reaches TIMEOUT_CYCLES-1 without dp_out_vld → rsp_data <= 0, rsp_timeout <= 1, go to RESP.
  - dp_out_vld on the same cycle as the timeout → the result wins (rsp_timeout = 0).
- RESP:
  - rsp_vld = 1, rsp_id = gnt_id.
  - rsp_data, rsp_id and rsp_timeout are held stable until rsp_rdy.
  - On rsp_rdy: rsp_vld goes 0 next cycle, rr_ptr <= gnt_id+1 (wrapping NUM_REQ-1 → 0), go to IDLE.
  - A new grant is possible in the cycle after return to IDLE.
- dp_poly holds the granted polynomial through STREAM, WAIT and RESP. It changes only at the next grant.
- Fairness: a requester that holds req_vld continuously is granted within NUM_REQ jobs.
- Throughput: a burst of N words with immediate dp_out_vld and rsp_rdy takes 1 (grant) + N + 1 (WAIT) + 1 (RESP) cycles.

Decomposition:
- Package checksum_sched_pkg holds:
  - FSM state encoding constants IDLE=0, STREAM=1, WAIT=2, RESP=3.
  - Default widths (17/17/34) shared with checksum_top.
- One sub-module, sched_rr_arbiter: combinational round-robin select.
  - Inputs: req vector and rr_ptr. Outputs: one-hot grant and encoded id.
  - Instantiated once. The FSM, data capture and timeout counter stay in the top module.

Test Plan:
- Req 2 only, 3-word burst 0x00001, 0x00002, 0x1FFFF, poly 0x0A5A5; dp_out_vld 2 cycles after last with 0x123456789 → rsp_id=2, rsp_data=0x123456789, rsp_timeout=0; dp_poly=0x0A5A5 from the grant through the rsp_rdy handshake.
- All 4 requesters hold req_vld, single-word bursts, immediate dp_out_vld, rsp_rdy tied high → grant order 0,1,2,3,0; each job takes 4 cycles.
- dp_out_vld never asserted → rsp_vld exactly TIMEOUT_CYCLES cycles after entering WAIT, rsp_data=0, rsp_timeout=1; next requester served afterwards.
- rsp_rdy held low 10 cycles in RESP while req 1 raises req_vld → rsp fields stable, req_rdy stays 0, req 1 granted the cycle after return to IDLE.
- Assert reset low mid-STREAM of a 5-word burst (after word 2) → all outputs 0 immediately; after release the next job starts from rr_ptr=0 with no residual dp_in_vld.
- Spurious dp_out_vld pulse during STREAM, then the real one in WAIT → only the WAIT-cycle dp_out_data appears on rsp_data.
